// File: rtl/instruction_fetch.sv
// instruction_fetch: PC register, IF/ID pipeline register and fetch counter with BOOT/RUN/TRAP control.
// Optional MISALIGN_TRAP_EN traps misaligned redirects instead of forcing word alignment.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        IF_clk,
    input  logic        IF_rst_n,
    input  logic        IF_stall,
    input  logic        IF_flush,
    input  logic        IF_redirect,
    input  logic [31:0] IF_target,
    input  logic [31:0] IF_imem_instr,
    output logic [31:0] IF_pc,
    output logic [31:0] IF_id_instr,
    output logic [31:0] IF_id_pc4,
    output logic        IF_id_valid,
    output logic [31:0] IF_fetch_cnt,
    output logic        IF_misalign
);
    typedef enum logic [1:0] {BOOT, RUN, TRAP} state_t;
    state_t state;
    logic [31:0] pc4;
    logic bad_target;
    assign pc4 = IF_pc + 32'd4;
`ifdef MISALIGN_TRAP_EN
    assign bad_target = IF_target[1:0] != 2'b00;
`else
    assign bad_target = 1'b0;
    assign IF_misalign = 1'b0;
`endif
    always_ff @(posedge IF_clk or negedge IF_rst_n) begin
        if (!IF_rst_n) begin
            state        <= BOOT;
            IF_pc        <= RESET_PC;
            IF_id_instr  <= 32'd0;
            IF_id_pc4    <= 32'd0;
            IF_id_valid  <= 1'b0;
            IF_fetch_cnt <= 32'd0;
`ifdef MISALIGN_TRAP_EN
            IF_misalign  <= 1'b0;
`endif
        end else begin
            case (state)
                BOOT: state <= RUN;
                RUN: begin
                    if (IF_redirect || IF_flush) begin
                        IF_id_instr <= 32'd0;
                        IF_id_pc4   <= 32'd0;
                        IF_id_valid <= 1'b0;
                    end
                    if (IF_redirect) begin
                        if (bad_target) begin
                            state <= TRAP;
`ifdef MISALIGN_TRAP_EN
                            IF_misalign <= 1'b1;
`endif
                        end else begin
                            IF_pc <= {IF_target[31:2], 2'b00};
                        end
                    end else if (!IF_stall) begin
                        IF_pc <= pc4;
                        if (!IF_flush) begin
                            IF_id_instr  <= IF_imem_instr;
                            IF_id_pc4    <= pc4;
                            IF_id_valid  <= 1'b1;
                            IF_fetch_cnt <= IF_fetch_cnt + 32'd1;
                        end
                    end
                end
                default: IF_id_valid <= 1'b0;
            endcase
        end
    end
endmodule
